reg_scoreboard: RTL and testbench



---
 rtl/reg_scoreboard_pkg.sv | 22 ++
 rtl/reg_scoreboard_if.sv | 46 ++++
 rtl/reg_scoreboard_cnt.sv | 46 ++++
 rtl/reg_scoreboard.sv | 84 ++++++++
 tb/tb_reg_scoreboard.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/reg_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_scoreboard_pkg
//  Purpose  : Shared constants and types for the register hazard scoreboard.
//             REG_BITS  - width of a register specifier
//             NUM_REGS  - number of tracked architectural registers
//             MAX_PEND  - maximum in-flight writes per register
//             CNT_W     - width of a per-register pending counter
//  Revision : 1.0 - initial release
// ============================================================================
package reg_scoreboard_pkg;

  localparam int REG_BITS = 5;
  localparam int NUM_REGS = 1 << REG_BITS;
  localparam int MAX_PEND = 3;
  localparam int CNT_W    = $clog2(MAX_PEND + 1);

  typedef logic [REG_BITS-1:0] reg_id_t;
  typedef logic [CNT_W-1:0]    cnt_t;

endpackage : reg_scoreboard_pkg
`default_nettype wire

// File: rtl/reg_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_scoreboard_if
//  Purpose  : Issue / writeback / squash bundle between the pipeline and the
//             scoreboard.
//             master - pipeline side: drives issue, writeback and kill fields,
//                      receives stall, issue_accept, busy and err
//             slave  - scoreboard side: the mirror image
//  Revision : 1.0 - initial release
// ============================================================================
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  // decode-stage issue request
  logic    issue_valid;
  reg_id_t issue_rs;
  logic    issue_rs_en;
  reg_id_t issue_rt;
  logic    issue_rt_en;
  reg_id_t issue_rd;
  logic    issue_wr_en;
  logic    stall;
  logic    issue_accept;
  // writeback retire and squash
  logic    wb_valid;
  reg_id_t wb_rd;
  logic    kill_valid;
  reg_id_t kill_rd;
  // status
  logic    busy;
  logic    err;

  modport master (
    output issue_valid, issue_rs, issue_rs_en, issue_rt, issue_rt_en,
           issue_rd, issue_wr_en, wb_valid, wb_rd, kill_valid, kill_rd,
    input  stall, issue_accept, busy, err
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rs_en, issue_rt, issue_rt_en,
           issue_rd, issue_wr_en, wb_valid, wb_rd, kill_valid, kill_rd,
    output stall, issue_accept, busy, err
  );

endinterface : reg_scoreboard_if
`default_nettype wire

// File: rtl/reg_scoreboard_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : reg_scoreboard_cnt
//  Purpose  : Pending-write counter for one architectural register.
//             clk, rst     - clock, asynchronous active-high reset
//             inc_i        - one write to this register issued this cycle
//             dec_i        - writes retired/squashed this cycle (0..2)
//             cnt_o        - current pending count
//             pend_d_o     - next-state count is nonzero
//             underflow_o  - this cycle's update would go below zero
//  Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard_cnt
  import reg_scoreboard_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_i,
  input  logic [1:0] dec_i,
  output cnt_t       cnt_o,
  output logic       pend_d_o,
  output logic       underflow_o
);

  cnt_t             cnt_q;
  cnt_t             cnt_d;
  // One extra bit so cnt + inc never wraps before the decrement is applied.
  logic [CNT_W:0]   up;
  logic [CNT_W:0]   dec_ext;

  assign up          = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inc_i};
  assign dec_ext     = {{(CNT_W-1){1'b0}}, dec_i};
  assign underflow_o = (up < dec_ext);
  // Clamp at zero on underflow. Overflow past MAX_PEND is prevented upstream
  // by the full-destination stall, so the truncation never loses a count.
  assign cnt_d       = underflow_o ? '0 : CNT_W'(up - dec_ext);
  assign pend_d_o    = (cnt_d != '0);
  assign cnt_o       = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule : reg_scoreboard_cnt
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : reg_scoreboard
//  Purpose  : Destination-side register hazard tracker. Keeps a pending-write
//             count per register from issue to writeback/squash and stalls
//             decode when a source is pending or the destination is full.
//             clk, rst  - clock, asynchronous active-high reset
//             sb        - issue/writeback/kill bundle (slave side)
//  Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter bit ZERO_HARDWIRED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  reg_scoreboard_if.slave  sb
);

  cnt_t                cnt [NUM_REGS];
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] pend_d;
  logic [NUM_REGS-1:0] underflow;

  logic stall;
  logic accept;
  logic rs_hit;
  logic rt_hit;
  logic rd_full;
  logic busy_q;
  logic err_q;

  // Lookups see only the registered counts: a same-cycle writeback does not
  // release the stall until the following cycle.
  assign rs_hit  = sb.issue_rs_en && (cnt[sb.issue_rs] != '0);
  assign rt_hit  = sb.issue_rt_en && (cnt[sb.issue_rt] != '0);
  assign rd_full = sb.issue_wr_en && (cnt[sb.issue_rd] == cnt_t'(MAX_PEND));
  assign stall   = sb.issue_valid && (rs_hit || rt_hit || rd_full);
  assign accept  = sb.issue_valid && !stall;

  assign sb.stall        = stall;
  assign sb.issue_accept = accept;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    // With a hardwired zero register, r0 sees no events at all, so it can
    // never become pending nor flag an underflow.
    localparam bit IS_ZERO = ZERO_HARDWIRED && (r == 0);
    logic [1:0] dec;

    assign inc[r] = !IS_ZERO && accept && sb.issue_wr_en
                    && (sb.issue_rd == reg_id_t'(r));
    assign dec    = IS_ZERO ? 2'd0
                  : ({1'b0, sb.wb_valid   && (sb.wb_rd   == reg_id_t'(r))}
                   + {1'b0, sb.kill_valid && (sb.kill_rd == reg_id_t'(r))});

    reg_scoreboard_cnt u_cnt (
      .clk         (clk),
      .rst         (rst),
      .inc_i       (inc[r]),
      .dec_i       (dec),
      .cnt_o       (cnt[r]),
      .pend_d_o    (pend_d[r]),
      .underflow_o (underflow[r])
    );
  end

  // busy follows the next-state counts so it matches the counters after the
  // edge; err is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= |pend_d;
      err_q  <= err_q || (|underflow);
    end
  end

  assign sb.busy = busy_q;
  assign sb.err  = err_q;

endmodule : reg_scoreboard
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_scoreboard
//  Purpose  : Self-checking bench for reg_scoreboard. Two instances (register
//             zero tracked / hardwired) see identical stimulus and are compared
//             against a count-per-register reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       iv, rse, rte, we, wbv, kv;
  logic [4:0] rs, rt, rd, wbr, kr;

  reg_scoreboard_if sb0 ();
  reg_scoreboard_if sb1 ();

  assign sb0.issue_valid = iv;  assign sb1.issue_valid = iv;
  assign sb0.issue_rs    = rs;  assign sb1.issue_rs    = rs;
  assign sb0.issue_rs_en = rse; assign sb1.issue_rs_en = rse;
  assign sb0.issue_rt    = rt;  assign sb1.issue_rt    = rt;
  assign sb0.issue_rt_en = rte; assign sb1.issue_rt_en = rte;
  assign sb0.issue_rd    = rd;  assign sb1.issue_rd    = rd;
  assign sb0.issue_wr_en = we;  assign sb1.issue_wr_en = we;
  assign sb0.wb_valid    = wbv; assign sb1.wb_valid    = wbv;
  assign sb0.wb_rd       = wbr; assign sb1.wb_rd       = wbr;
  assign sb0.kill_valid  = kv;  assign sb1.kill_valid  = kv;
  assign sb0.kill_rd     = kr;  assign sb1.kill_rd     = kr;

  reg_scoreboard #(.ZERO_HARDWIRED(1'b0)) u_dut0 (.clk(clk), .rst(rst), .sb(sb0));
  reg_scoreboard #(.ZERO_HARDWIRED(1'b1)) u_dut1 (.clk(clk), .rst(rst), .sb(sb1));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_cnt [2][32];
  bit m_err [2];
  bit m_busy[2];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_stall(int d);
    return iv && ((rse && m_cnt[d][rs] > 0) || (rte && m_cnt[d][rt] > 0)
                  || (we && m_cnt[d][rd] == 3));
  endfunction

  function automatic void m_reset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 32; r++) m_cnt[d][r] = 0;
      m_err[d]  = 0;
      m_busy[d] = 0;
    end
  endfunction

  // Apply one clock of events to the model, using the pre-edge state.
  function automatic void m_update();
    for (int d = 0; d < 2; d++) begin
      bit acc = iv && !m_stall(d);
      m_busy[d] = 0;
      for (int r = 0; r < 32; r++) begin
        int n;
        if (d == 1 && r == 0) continue;   // hardwired zero: never tracked
        n = m_cnt[d][r] + int'(acc && we && rd == r)
                        - int'(wbv && wbr == r) - int'(kv && kr == r);
        if (n < 0) begin
          n = 0;
          m_err[d] = 1;
        end
        m_cnt[d][r] = n;
        if (n != 0) m_busy[d] = 1;
      end
    end
  endfunction

  // Called just after a falling edge with inputs set: compare all outputs.
  task automatic settle();
    #1;
    chk("stall0",  sb0.stall,        32'(m_stall(0)));
    chk("accept0", sb0.issue_accept, 32'(iv && !m_stall(0)));
    chk("busy0",   sb0.busy,         32'(m_busy[0]));
    chk("err0",    sb0.err,          32'(m_err[0]));
    chk("stall1",  sb1.stall,        32'(m_stall(1)));
    chk("accept1", sb1.issue_accept, 32'(iv && !m_stall(1)));
    chk("busy1",   sb1.busy,         32'(m_busy[1]));
    chk("err1",    sb1.err,          32'(m_err[1]));
  endtask

  task automatic tick();
    m_update();
    @(negedge clk);
  endtask

  task automatic idle();
    iv = 0; rse = 0; rte = 0; we = 0; wbv = 0; kv = 0;
    rs = 0; rt = 0; rd = 0; wbr = 0; kr = 0;
  endtask

  task automatic iss(input logic [4:0] a, input logic ae, input logic [4:0] b,
                     input logic be, input logic [4:0] d, input logic de);
    iv = 1; rs = a; rse = ae; rt = b; rte = be; rd = d; we = de;
  endtask

  // Asynchronous reset pulse in the middle of the low clock phase.
  task automatic async_reset();
    idle();
    #2 rst = 1'b1;
    #1;
    m_reset();
    chk("rst busy0", sb0.busy, 32'd0);
    chk("rst err0",  sb0.err,  32'd0);
    chk("rst busy1", sb1.busy, 32'd0);
    chk("rst err1",  sb1.err,  32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [4:0] pick_pending();
    int s = $urandom_range(0, 31);
    for (int i = 0; i < 32; i++)
      if (m_cnt[0][(s + i) % 32] > 0) return 5'((s + i) % 32);
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    settle();
    chk("reset stall", sb0.stall, 32'd0);

    // issue r5, then a reader of r5 stalls until one cycle after writeback
    iss(5'd0, 0, 5'd0, 0, 5'd5, 1); settle();
    chk("tp1 accept", sb0.issue_accept, 32'd1); tick();
    iss(5'd5, 1, 5'd0, 0, 5'd0, 0); settle();
    chk("tp1 stall", sb0.stall, 32'd1); tick();
    wbv = 1; wbr = 5'd5; settle();
    chk("tp1 stall wb", sb0.stall, 32'd1); tick();
    wbv = 0; settle();
    chk("tp1 release", sb0.stall, 32'd0);
    chk("tp1 busy", sb0.busy, 32'd0); tick();

    // fill r7 to MAX_PEND, fourth writer waits for a retire
    repeat (3) begin iss(5'd1, 0, 5'd2, 0, 5'd7, 1); settle(); tick(); end
    iss(5'd1, 1, 5'd2, 1, 5'd7, 1); settle();
    chk("tp2 full", sb0.stall, 32'd1); tick();
    wbv = 1; wbr = 5'd7; settle();
    chk("tp2 full wb", sb0.stall, 32'd1); tick();
    wbv = 0; settle();
    chk("tp2 accept", sb0.issue_accept, 32'd1); tick();
    iss(5'd1, 0, 5'd2, 0, 5'd7, 1); settle();
    chk("tp2 still full", sb0.stall, 32'd1); tick();
    idle(); wbv = 1; wbr = 5'd7;
    repeat (3) begin settle(); tick(); end
    idle();

    // same-cycle inc/dec on r9, then wb+kill together
    iss(5'd0, 0, 5'd0, 0, 5'd9, 1); settle(); tick();
    wbv = 1; wbr = 5'd9; settle();
    chk("tp3 accept", sb0.issue_accept, 32'd1); tick();
    wbv = 0; settle(); tick();
    wbv = 1; wbr = 5'd9; kv = 1; kr = 5'd9; iv = 0; settle(); tick();
    idle(); iss(5'd9, 1, 5'd9, 1, 5'd9, 0); settle();
    chk("tp3 r9 free", sb0.stall, 32'd0);
    chk("tp3 busy", sb0.busy, 32'd0);
    chk("tp3 err", sb0.err, 32'd0); tick();

    // underflow on r12 sets sticky err
    idle(); wbv = 1; wbr = 5'd12; settle(); tick();
    idle(); repeat (3) begin settle(); tick(); end
    chk("tp4 err", sb0.err, 32'd1);

    // register zero on the hardwired instance
    async_reset();
    iss(5'd0, 0, 5'd0, 0, 5'd0, 1); settle(); tick();
    iss(5'd0, 1, 5'd0, 0, 5'd3, 0); settle();
    chk("tp5 r0 stall", sb1.stall, 32'd0);
    chk("tp5 r0 busy", sb1.busy, 32'd0); tick();
    idle(); kv = 1; kr = 5'd0; settle(); tick();
    idle(); settle();
    chk("tp5 r0 err", sb1.err, 32'd0); tick();

    // async reset with several registers pending
    iss(5'd0, 0, 5'd0, 0, 5'd3, 1); settle(); tick();
    iss(5'd0, 0, 5'd0, 0, 5'd4, 1); settle(); tick();
    iss(5'd0, 0, 5'd0, 0, 5'd6, 1); settle(); tick();
    async_reset();
    iss(5'd3, 1, 5'd4, 1, 5'd6, 1); settle();
    chk("tp6 stall", sb0.stall, 32'd0); tick();
    async_reset();

    // random traffic over a small register window
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        async_reset();
        continue;
      end
      iv  = ($urandom_range(0, 9) < 7);
      rs  = 5'($urandom_range(0, 7)); rse = 1'($urandom);
      rt  = 5'($urandom_range(0, 7)); rte = 1'($urandom);
      rd  = 5'($urandom_range(0, 7)); we  = ($urandom_range(0, 3) != 0);
      wbv = ($urandom_range(0, 2) == 0);
      wbr = ($urandom_range(0, 11) == 0) ? 5'($urandom_range(0, 7)) : pick_pending();
      kv  = ($urandom_range(0, 7) == 0);
      kr  = pick_pending();
      settle();
      tick();
    end

    idle();
    settle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_reg_scoreboard
`default_nettype wire
